// File: rtl/phy_tx_scheduler_if.sv
// Word-level handshake between the payload source and the PHY transmit scheduler,
// plus the registered output word bus toward the lane striper.
interface phy_tx_scheduler_if;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready_out;
    logic        retrain;
    logic [31:0] tx_data;
    logic [3:0]  tx_k;
    logic        tx_valid;
    logic        link_up;

    modport master (
        output data_in, valid_in, retrain,
        input  ready_out, tx_data, tx_k, tx_valid, link_up
    );

    modport slave (
        input  data_in, valid_in, retrain,
        output ready_out, tx_data, tx_k, tx_valid, link_up
    );
endinterface

// File: rtl/phy_tx_scheduler.sv
// PHY transmit word scheduler: TS training bursts, then payload/IDLE with periodic SKP.
// state | meaning
// TRAIN | emitting TS words until TS_COUNT have gone out since the last (re)start
// LINK  | emitting payload or IDLE, with a SKP every SKP_INTERVAL words
module phy_tx_scheduler #(
    parameter int TS_COUNT     = 16,
    parameter int SKP_INTERVAL = 64
) (
    input  logic              clk_2f,
    input  logic              reset,
    phy_tx_scheduler_if.slave bus
);
    localparam logic [31:0] TS_WORD   = 32'hBC4A_4A4A;
    localparam logic [31:0] SKP_WORD  = 32'hBC1C_1C1C;
    localparam logic [31:0] IDLE_WORD = 32'h7C7C_7C7C;

    typedef enum logic {TRAIN = 1'b0, LINK = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [7:0]  ts_cnt, ts_cnt_nxt;
    logic [11:0] skp_cnt, skp_cnt_nxt;
    logic [31:0] data_nxt;
    logic [3:0]  k_nxt;
    logic        link_up_nxt;
    logic        ts_last;
    logic        skp_due;

    assign ts_last       = (ts_cnt == 8'(TS_COUNT - 1));
    assign skp_due       = (state == LINK) && (skp_cnt == 12'(SKP_INTERVAL - 1));
    assign bus.ready_out = (state == LINK) && !skp_due && !bus.retrain;

    always_comb begin
        state_nxt   = state;
        ts_cnt_nxt  = ts_cnt;
        skp_cnt_nxt = skp_cnt;
        data_nxt    = IDLE_WORD;
        k_nxt       = 4'b1111;
        link_up_nxt = 1'b0;
        case (state)
            TRAIN: begin
                data_nxt = TS_WORD;
                k_nxt    = 4'b1000;
                if (bus.retrain) begin
                    ts_cnt_nxt = '0;
                end else if (ts_last) begin
                    ts_cnt_nxt  = '0;
                    skp_cnt_nxt = '0;
                    state_nxt   = LINK;
                end else begin
                    ts_cnt_nxt = ts_cnt + 8'd1;
                end
            end
            LINK: begin
                if (bus.retrain) begin
                    // The retrain word itself is the first TS of the new burst.
                    data_nxt    = TS_WORD;
                    k_nxt       = 4'b1000;
                    skp_cnt_nxt = '0;
                    if (TS_COUNT == 1) begin
                        ts_cnt_nxt = '0;
                    end else begin
                        ts_cnt_nxt = 8'd1;
                        state_nxt  = TRAIN;
                    end
                end else begin
                    link_up_nxt = 1'b1;
                    if (skp_due) begin
                        data_nxt    = SKP_WORD;
                        skp_cnt_nxt = '0;
                    end else begin
                        skp_cnt_nxt = skp_cnt + 12'd1;
                        if (bus.valid_in) begin
                            data_nxt = bus.data_in;
                            k_nxt    = 4'b0000;
                        end
                    end
                end
            end
            default: state_nxt = TRAIN;
        endcase
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state        <= TRAIN;
            ts_cnt       <= '0;
            skp_cnt      <= '0;
            bus.tx_data  <= '0;
            bus.tx_k     <= '0;
            bus.tx_valid <= 1'b0;
            bus.link_up  <= 1'b0;
        end else begin
            state        <= state_nxt;
            ts_cnt       <= ts_cnt_nxt;
            skp_cnt      <= skp_cnt_nxt;
            bus.tx_data  <= data_nxt;
            bus.tx_k     <= k_nxt;
            bus.tx_valid <= 1'b1;
            bus.link_up  <= link_up_nxt;
        end
    end
endmodule

// File: doc/phy_tx_scheduler.md
PHY_TX_SCHEDULER -- requirements
Module: phy_tx_scheduler

Interface
REQ-001 Parameter TS_COUNT, default 16: number of TS1 words sent per training sequence (legal 1..255).
REQ-002 Parameter SKP_INTERVAL, default 64: link-state words per SKP slot, SKP word included (legal 2..4095).
REQ-003 clk_2f  input  1  word clock; the only clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk_2f.
REQ-005 data_in  input  32  payload word; bits [31:24] are the first symbol on the wire.
REQ-006 valid_in  input  1  data_in holds a valid payload word.
REQ-007 ready_out  output  1  scheduler accepts data_in this cycle; combinational from state and counters only, never from valid_in.
REQ-008 retrain  input  1  single-cycle request to re-enter training.
REQ-009 tx_data  output  32  registered word toward the two-lane byte striper/serializer.
REQ-010 tx_k  output  4  registered control-symbol flags, bit 3 = byte [31:24].
REQ-011 tx_valid  output  1  registered; tx_data/tx_k meaningful.
REQ-012 link_up  output  1  registered; high while in LINK state.

Function
REQ-013 Handshake: transfer occurs in a cycle where valid_in=1 and ready_out=1; the accepted word appears on tx_data with tx_k=4'b0000 in the following cycle (1-cycle latency), with no buffering.
REQ-014 Fixed words: TS word = 32'hBC4A_4A4A, tx_k=4'b1000; SKP word = 32'hBC1C_1C1C, tx_k=4'b1111; IDLE word = 32'h7C7C_7C7C, tx_k=4'b1111.
REQ-015 States: TRAIN and LINK only; state held in a registered 1-bit or one-hot encoding.
REQ-016 TRAIN: emits one TS word per cycle; ready_out=0; ts_cnt counts emitted TS words from 0.
REQ-017 TRAIN -> LINK when the TS_COUNT-th TS word is being registered; the next output is a link-state word; ts_cnt clears.
REQ-018 LINK: per cycle, next output word priority: retrain (TS) > SKP due > accepted payload > IDLE.
REQ-019 skp_cnt (12 bits) counts words emitted in LINK; SKP is due when skp_cnt == SKP_INTERVAL-1; that cycle ready_out=0, next output is SKP, skp_cnt wraps to 0.
REQ-020 ready_out = 1 in LINK exactly when no SKP is due and retrain=0.
REQ-021 LINK with no transfer and no SKP due: next output is IDLE; skp_cnt still increments.
REQ-022 retrain=1 in LINK: next output is first TS word, state -> TRAIN, ts_cnt and skp_cnt clear, link_up falls with that word; payload presented that cycle is not accepted.
REQ-023 retrain=1 in TRAIN: ts_cnt restarts so that TS_COUNT further TS words follow the current cycle.
REQ-024 retrain coinciding with SKP due: retrain wins, no SKP emitted.
REQ-025 tx_valid=1 in every cycle after the first post-reset clock edge; no gap words are ever emitted.
REQ-026 Counters never exceed their terminal values; no arithmetic overflow paths.

Reset
REQ-027 While reset=1 at a clock edge: state=TRAIN, ts_cnt=0, skp_cnt=0, tx_data=32'h0, tx_k=4'b0000, tx_valid=0, link_up=0, ready_out=0.
REQ-028 First edge with reset=0 registers the first TS word; reset asserted mid-operation (any state, any count) restores REQ-027 values at the next edge, discarding any in-flight word.

Verification (bench parameters TS_COUNT=4, SKP_INTERVAL=8)
REQ-029 Release reset, valid_in=0 -> 4 cycles tx_data=BC4A4A4A/k=1000, then link_up=1, 7 IDLE words (7C7C7C7C/k=1111), then SKP BC1C1C1C/k=1111, pattern repeating.
REQ-030 After link_up, valid_in=1 continuously with words FFDDFFDD, EEAAEEAA, DDFFAABB, CABFFABC repeating -> each appears one cycle after acceptance, k=0000; ready_out=0 every 8th link word, that data word held and sent after SKP, no word lost or duplicated.
REQ-031 Pulse retrain in the cycle SKP is due -> no SKP emitted, next 4 words TS, link_up low for those 4 words, skp_cnt restarts (first SKP 8 link words after return).
REQ-032 Pulse retrain during 2nd TS word -> 4 further TS words follow (6 total) before LINK.
REQ-033 Assert reset for 1 cycle mid-payload stream -> next cycle tx_valid=0, tx_data=0, link_up=0, ready_out=0; training restarts with 4 TS words.
REQ-034 Random valid_in for 2000 cycles -> scoreboard: output payload sequence equals accepted sequence, SKP exactly every 8 link words, ready_out independent of valid_in.
